mips_mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the 8-bit MIPS core. Sequences 4-byte instruction fetch, decode, execute,

---
 rtl/mips_mc_ctrl_pkg.sv | 72 +++++++
 rtl/mips_mc_ctrl_if.sv | 33 +++
 rtl/mips_mc_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, datapath select codes, state encoding.
// Optional ADDI support is compiled in when MIPS_ADDI_EN is defined.
package mips_mc_ctrl_pkg;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd15;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH1  = 4'd1,
    S_FETCH2  = 4'd2,
    S_FETCH3  = 4'd3,
    S_FETCH4  = 4'd4,
    S_DECODE  = 4'd5,
    S_MEMADR  = 4'd6,
    S_LBRD    = 4'd7,
    S_LBWR    = 4'd8,
    S_SBWR    = 4'd9,
    S_RTYPEEX = 4'd10,
    S_RTYPEWR = 4'd11,
    S_BEQEX   = 4'd12,
    S_JEX     = 4'd13
`ifdef MIPS_ADDI_EN
    ,
    S_ADDIEX  = 4'd14,
    S_ADDIWR  = 4'd15
`endif
  } state_t;

  // States that wait on the memory handshake and are subject to the timeout.
  function automatic logic is_mem_state(input state_t s);
    logic m;
    case (s)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_LBRD, S_SBWR: m = 1'b1;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Instruction-register byte lane loaded by each fetch state.
  function automatic logic [3:0] fetch_lane(input state_t s);
    logic [3:0] oh;
    case (s)
      S_FETCH1: oh = 4'b0001;
      S_FETCH2: oh = 4'b0010;
      S_FETCH3: oh = 4'b0100;
      S_FETCH4: oh = 4'b1000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath/memory (slave).
interface mips_mc_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memread;
  logic       memwrite;
  logic       iord;
  logic [3:0] irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       pcen;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_err;

  modport master (
    input  op, zero, mem_ready,
    output memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsource, pcen, instr_done, illegal_op, mem_err
  );

  modport slave (
    output op, zero, mem_ready,
    input  memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsource, pcen, instr_done, illegal_op, mem_err
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the 8-bit MIPS core: 4-byte fetch, decode, execute, memory, writeback.
// Define MIPS_ADDI_EN to add the ADDI execute/writeback states.
module mips_mc_ctrl
  import mips_mc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  mips_mc_ctrl_if.master bus
);

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 32'd1);

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] wait_cnt_r;
  logic       mem_state_s;
  logic       timeout_s;

  logic       memread_s;
  logic       memwrite_s;
  logic       iord_s;
  logic [3:0] irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] aluop_s;
  logic [1:0] pcsource_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic       instr_done_s;
  logic       illegal_op_s;
  logic       mem_err_s;

  assign mem_state_s = is_mem_state(state_r);
  // The stall that would make the counter reach TIMEOUT aborts; ready on that cycle still wins.
  assign timeout_s   = mem_state_s && !bus.mem_ready && (wait_cnt_r == WAIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Memory wait counter: counts stalled cycles, cleared whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 4'd0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= 4'd0;
    end else if (mem_state_s && !bus.mem_ready) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= 4'd0;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state_s = state_r;
    memread_s    = 1'b0;
    memwrite_s   = 1'b0;
    iord_s       = 1'b0;
    irwrite_s    = 4'b0000;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = SRCB_REGB;
    aluop_s      = ALUOP_ADD;
    pcsource_s   = PCSRC_ALU;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    instr_done_s = 1'b0;
    illegal_op_s = 1'b0;
    mem_err_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        next_state_s = S_FETCH1;
      end

      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        memread_s = 1'b1;
        alusrcb_s = SRCB_ONE;
        if (bus.mem_ready) begin
          irwrite_s = fetch_lane(state_r);
          pcwrite_s = 1'b1;
          case (state_r)
            S_FETCH1: next_state_s = S_FETCH2;
            S_FETCH2: next_state_s = S_FETCH3;
            S_FETCH3: next_state_s = S_FETCH4;
            default:  next_state_s = S_DECODE;
          endcase
        end else if (timeout_s) begin
          mem_err_s    = 1'b1;
          next_state_s = S_FETCH1;
        end else begin
          next_state_s = state_r;
        end
      end

      S_DECODE: begin
        alusrcb_s = SRCB_BOFF;
        case (bus.op)
          OP_LB, OP_SB: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_RTYPEEX;
          OP_BEQ:       next_state_s = S_BEQEX;
          OP_J:         next_state_s = S_JEX;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      next_state_s = S_ADDIEX;
`endif
          default: begin
            illegal_op_s = 1'b1;
            next_state_s = S_FETCH1;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = SRCB_IMM;
        if (bus.op == OP_LB) begin
          next_state_s = S_LBRD;
        end else begin
          next_state_s = S_SBWR;
        end
      end

      S_LBRD: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_LBWR;
        end else if (timeout_s) begin
          mem_err_s    = 1'b1;
          next_state_s = S_FETCH1;
        end else begin
          next_state_s = state_r;
        end
      end

      S_LBWR: begin
        regwrite_s   = 1'b1;
        memtoreg_s   = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH1;
      end

      S_SBWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
        if (bus.mem_ready) begin
          instr_done_s = 1'b1;
          next_state_s = S_FETCH1;
        end else if (timeout_s) begin
          mem_err_s    = 1'b1;
          next_state_s = S_FETCH1;
        end else begin
          next_state_s = state_r;
        end
      end

      S_RTYPEEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_REGB;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = S_RTYPEWR;
      end

      S_RTYPEWR: begin
        regwrite_s   = 1'b1;
        regdst_s     = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH1;
      end

      S_BEQEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_REGB;
        aluop_s      = ALUOP_SUB;
        pcsource_s   = PCSRC_ALUOUT;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH1;
      end

      S_JEX: begin
        pcsource_s   = PCSRC_JUMP;
        pcwrite_s    = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH1;
      end

`ifdef MIPS_ADDI_EN
      S_ADDIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_IMM;
        aluop_s      = ALUOP_ADD;
        next_state_s = S_ADDIWR;
      end

      S_ADDIWR: begin
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
        next_state_s = S_FETCH1;
      end
`endif

      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  assign bus.memread    = memread_s;
  assign bus.memwrite   = memwrite_s;
  assign bus.iord       = iord_s;
  assign bus.irwrite    = irwrite_s;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.regwrite   = regwrite_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.aluop      = aluop_s;
  assign bus.pcsource   = pcsource_s;
  assign bus.pcen       = pcwrite_s | (branch_s & bus.zero);
  assign bus.instr_done = instr_done_s;
  assign bus.illegal_op = illegal_op_s;
  assign bus.mem_err    = mem_err_s;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle expected output vectors queued and compared mid-cycle.
// Honours MIPS_ADDI_EN to pick the expected ADDI behaviour.
module tb_mips_mc_ctrl;
  import mips_mc_ctrl_pkg::*;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       pcen;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  outs_t exp_q[$];
  string tag_q[$];

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t observe();
    outs_t o;
    o.memread    = bus.memread;
    o.memwrite   = bus.memwrite;
    o.iord       = bus.iord;
    o.irwrite    = bus.irwrite;
    o.regdst     = bus.regdst;
    o.memtoreg   = bus.memtoreg;
    o.regwrite   = bus.regwrite;
    o.alusrca    = bus.alusrca;
    o.alusrcb    = bus.alusrcb;
    o.aluop      = bus.aluop;
    o.pcsource   = bus.pcsource;
    o.pcen       = bus.pcen;
    o.instr_done = bus.instr_done;
    o.illegal_op = bus.illegal_op;
    o.mem_err    = bus.mem_err;
    return o;
  endfunction

  // Expected output vectors, one per controller state, written from the state table.
  function automatic outs_t e_idle();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t e_fetch(input int n, input logic rdy, input logic err);
    outs_t o = '0;
    o.memread = 1'b1;
    o.alusrcb = 2'b01;
    o.irwrite = rdy ? 4'(1 << (n - 1)) : 4'b0000;
    o.pcen    = rdy;
    o.mem_err = err;
    return o;
  endfunction

  function automatic outs_t e_decode(input logic ill);
    outs_t o = '0;
    o.alusrcb    = 2'b11;
    o.illegal_op = ill;
    return o;
  endfunction

  function automatic outs_t e_memadr();
    outs_t o = '0;
    o.alusrca = 1'b1;
    o.alusrcb = 2'b10;
    return o;
  endfunction

  function automatic outs_t e_lbrd();
    outs_t o = '0;
    o.memread = 1'b1;
    o.iord    = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_lbwr();
    outs_t o = '0;
    o.regwrite   = 1'b1;
    o.memtoreg   = 1'b1;
    o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_sbwr(input logic rdy);
    outs_t o = '0;
    o.memwrite   = 1'b1;
    o.iord       = 1'b1;
    o.instr_done = rdy;
    return o;
  endfunction

  function automatic outs_t e_rex();
    outs_t o = '0;
    o.alusrca = 1'b1;
    o.aluop   = 2'b10;
    return o;
  endfunction

  function automatic outs_t e_rwr();
    outs_t o = '0;
    o.regwrite   = 1'b1;
    o.regdst     = 1'b1;
    o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_beq(input logic z);
    outs_t o = '0;
    o.alusrca    = 1'b1;
    o.aluop      = 2'b01;
    o.pcsource   = 2'b01;
    o.pcen       = z;
    o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_jex();
    outs_t o = '0;
    o.pcsource   = 2'b10;
    o.pcen       = 1'b1;
    o.instr_done = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_aex();
    outs_t o = '0;
    o.alusrca = 1'b1;
    o.alusrcb = 2'b10;
    return o;
  endfunction

  function automatic outs_t e_awr();
    outs_t o = '0;
    o.regwrite   = 1'b1;
    o.instr_done = 1'b1;
    return o;
  endfunction

  // Pop the oldest expectation and compare with what the controller drives now.
  task automatic check_one();
    outs_t exp_v;
    outs_t obs_v;
    string t;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    obs_v = observe();
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%06h expected=%06h", t, obs_v, exp_v);
    end
  endtask

  // One controller cycle: inputs already set by the caller just after the rising edge.
  task automatic cyc(input string tag, input outs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_one();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch();
    bus.mem_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      cyc($sformatf("fetch%0d", n), e_fetch(n, 1'b1, 1'b0));
    end
  endtask

  initial begin
    bus.op        = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_idle", e_idle());

    // Reset asserted while stalled in FETCH2.
    rst_n = 1'b1;
    cyc("idle_pre", e_idle());
    bus.mem_ready = 1'b1;
    cyc("f1_pre", e_fetch(1, 1'b1, 1'b0));
    bus.mem_ready = 1'b0;
    cyc("f2_stall", e_fetch(2, 1'b0, 1'b0));
    rst_n = 1'b0;
    cyc("async_rst_idle", e_idle());
    rst_n = 1'b1;
    cyc("idle_after_rst", e_idle());

    // R-type: FETCH1 first cycle after IDLE.
    bus.op = OP_RTYPE;
    run_fetch();
    cyc("r_decode", e_decode(1'b0));
    cyc("r_ex", e_rex());
    cyc("r_wr", e_rwr());

    // LB with three stalled read cycles.
    bus.op = OP_LB;
    run_fetch();
    cyc("lb_decode", e_decode(1'b0));
    cyc("lb_memadr", e_memadr());
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("lb_rd_stall", e_lbrd());
    end
    bus.mem_ready = 1'b1;
    cyc("lb_rd_ready", e_lbrd());
    cyc("lb_wr", e_lbwr());

    // SB with one stalled write cycle.
    bus.op = OP_SB;
    run_fetch();
    cyc("sb_decode", e_decode(1'b0));
    cyc("sb_memadr", e_memadr());
    bus.mem_ready = 1'b0;
    cyc("sb_wr_stall", e_sbwr(1'b0));
    bus.mem_ready = 1'b1;
    cyc("sb_wr_ready", e_sbwr(1'b1));

    // BEQ taken and not taken.
    bus.op = OP_BEQ;
    bus.zero = 1'b1;
    run_fetch();
    cyc("beq_decode", e_decode(1'b0));
    cyc("beq_taken", e_beq(1'b1));
    bus.zero = 1'b0;
    run_fetch();
    cyc("beq_decode2", e_decode(1'b0));
    cyc("beq_not_taken", e_beq(1'b0));

    // Jump.
    bus.op = OP_J;
    run_fetch();
    cyc("j_decode", e_decode(1'b0));
    cyc("j_ex", e_jex());

    // FETCH3 timeout after 15 stalled cycles.
    bus.mem_ready = 1'b1;
    cyc("to_f1", e_fetch(1, 1'b1, 1'b0));
    cyc("to_f2", e_fetch(2, 1'b1, 1'b0));
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      cyc("to_f3_stall", e_fetch(3, 1'b0, 1'b0));
    end
    cyc("to_f3_timeout", e_fetch(3, 1'b0, 1'b1));

    // Ready arriving on the 15th cycle is a success.
    bus.mem_ready = 1'b1;
    cyc("ok_f1", e_fetch(1, 1'b1, 1'b0));
    cyc("ok_f2", e_fetch(2, 1'b1, 1'b0));
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      cyc("ok_f3_stall", e_fetch(3, 1'b0, 1'b0));
    end
    bus.mem_ready = 1'b1;
    cyc("ok_f3_ready15", e_fetch(3, 1'b1, 1'b0));
    cyc("ok_f4", e_fetch(4, 1'b1, 1'b0));
    bus.op = 6'b111111;
    cyc("illegal_decode", e_decode(1'b1));

    // ADDI, enabled or illegal depending on build.
    bus.op = OP_ADDI;
    run_fetch();
`ifdef MIPS_ADDI_EN
    cyc("addi_decode", e_decode(1'b0));
    cyc("addi_ex", e_aex());
    cyc("addi_wr", e_awr());
`else
    cyc("addi_illegal", e_decode(1'b1));
`endif
    cyc("after_addi_f1", e_fetch(1, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
